time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter REPEAT_DLY, default 50: 100 Hz ticks that i_sw2 must be held before auto-repeat starts (0.5 s).
REQ-002 Parameter REPEAT_PER, default 10: 100 Hz ticks between auto-repeat increments (0.1 s).
REQ-003 Parameter BLINK_HALF, default 25: 100 Hz ticks per blink half-period (2 Hz blink).
REQ-004 Parameter IDLE_TIMEOUT, default 1000: 100 Hz ticks without a key press before SETUP or ALARM returns to CLOCK (10 s).
REQ-005 clk  input  1  50 MHz system clock; the only clock, and every flop is clocked on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 i_tick_100hz / i_tick_1hz  input  1 each  one-clk-wide enable pulses.
REQ-008 i_sw0..i_sw3  input  1 each  debounced key levels, active-low (0 = pressed); sw0 = mode, sw1 = position, sw2 = increment, sw3 = alarm enable.
REQ-009 i_max_hit_sec / i_max_hit_min  input  1 each  one-clk pulses from the time counters on wrap.
REQ-010 o_mode  output  2  0 = CLOCK, 1 = SETUP, 2 = ALARM.
REQ-011 o_position  output  2  0 = SEC, 1 = MIN, 2 = HOUR.
REQ-012 o_sec_inc / o_min_inc / o_hour_inc  output  1 each  one-clk increment enables for the time counters.
REQ-013 o_alarm_sec_inc / o_alarm_min_inc / o_alarm_hour_inc  output  1 each  one-clk increment enables for the alarm registers.
REQ-014 o_alarm_en  output  1  alarm armed.
REQ-015 o_blink_mask  output  3  bit 0 = sec, bit 1 = min, bit 2 = hour; 1 = blank this display field.

Function
REQ-016 A press is the 1->0 transition of a registered copy of i_swN; an action fires on the clk after the transition.
REQ-017 A sw0 press advances the mode CLOCK->SETUP->ALARM->CLOCK; the encoding 3 is unreachable and goes to CLOCK on the next clk.
REQ-018 Every mode change sets o_position to SEC, clears the idle counter and clears the blink phase.
REQ-019 A sw1 press advances the position SEC->MIN->HOUR->SEC in SETUP and ALARM; sw1 is ignored in CLOCK.
REQ-020 A sw3 press toggles o_alarm_en in every mode.
REQ-021 In CLOCK and ALARM: o_sec_inc = i_tick_1hz, o_min_inc = i_max_hit_sec and o_hour_inc = i_max_hit_min, all registered with 1-clk latency.
REQ-022 In SETUP, the timebase and carry inputs are ignored; the clock is halted.
REQ-023 A sw2 press emits one inc pulse on the selected field: the time field in SETUP, the alarm field in ALARM; sw2 has no effect in CLOCK.
REQ-024 Auto-repeat: while sw2 stays low, a hold counter counts i_tick_100hz; on reaching REPEAT_DLY, one pulse is emitted and then one more every REPEAT_PER ticks; releasing sw2 clears the counter.
REQ-025 The press and auto-repeat logic emit at most one inc pulse per clk.
REQ-026 If sw0 and sw2 are pressed in the same clk, the mode change wins and the increment is discarded.
REQ-027 If sw1 and sw2 are pressed in the same clk, the position change wins and the increment is discarded.
REQ-028 The idle counter counts i_tick_100hz in SETUP and ALARM and is cleared by any key press or by sw2 held low.
REQ-029 When the idle counter reaches IDLE_TIMEOUT, the mode becomes CLOCK on the next clk.
REQ-030 The blink phase toggles every BLINK_HALF ticks of i_tick_100hz.
REQ-031 o_blink_mask is the one-hot of o_position when the phase is 1 in SETUP or ALARM, and 000 otherwise.
REQ-032 o_blink_mask is forced to 000 while sw2 is held low.
REQ-033 All counters saturate or wrap only as stated; the counter widths hold IDLE_TIMEOUT without overflow.

Reset
REQ-034 While rst_n = 0 at a clk edge: o_mode = CLOCK, o_position = SEC, o_alarm_en = 0, o_blink_mask = 000, all inc outputs = 0, all counters = 0, and the switch history registers = 1 (released).
REQ-035 Reset asserted mid-hold or mid-SETUP aborts the operation; no inc pulse is emitted in the clk after reset is released.

Verification
REQ-036 Reset, then 3 i_tick_1hz pulses in CLOCK -> exactly 3 o_sec_inc pulses, each 1 clk after its tick.
REQ-037 Two sw0 presses, one sw1 press, then a sw2 tap -> o_mode = 2, o_position = 1, exactly one o_alarm_min_inc pulse, and o_sec_inc keeps following i_tick_1hz.
REQ-038 SETUP, HOUR selected, sw2 held for 100 ticks of i_tick_100hz -> 1 press pulse plus 6 repeat pulses (at ticks 50, 60, ..., 100) on o_hour_inc, and o_blink_mask = 000 throughout the hold.
REQ-039 SETUP left idle for 1000 ticks of i_tick_100hz -> o_mode = 0 on the next clk; the blink mask toggles 100 <-> 000 every 25 ticks before that.
REQ-040 sw0 and sw2 pressed in the same clk in SETUP -> mode becomes ALARM and no inc pulse is emitted.
REQ-041 Reset asserted during an auto-repeat hold -> all outputs at their reset values, and no inc pulse after release until a new press.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Key and timebase controller for a digital clock: mode/position selection,
// set-time and alarm increments with auto-repeat, idle timeout and field blinking.
module time_set_ctrl #(
  parameter int REPEAT_DLY   = 50,
  parameter int REPEAT_PER   = 10,
  parameter int BLINK_HALF   = 25,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_100hz,
  input  logic       i_tick_1hz,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_alarm_sec_inc,
  output logic       o_alarm_min_inc,
  output logic       o_alarm_hour_inc,
  output logic       o_alarm_en,
  output logic [2:0] o_blink_mask
);

  localparam int HOLD_MAX = REPEAT_DLY + REPEAT_PER;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int BLINK_W  = $clog2(BLINK_HALF + 1);

  localparam logic [HOLD_W-1:0]  HOLD_DLY_C   = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0]  HOLD_MAX_C   = HOLD_W'(HOLD_MAX);
  localparam logic [IDLE_W-1:0]  IDLE_MAX_C   = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [BLINK_W-1:0] BLINK_HALF_C = BLINK_W'(BLINK_HALF);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  mode_e              mode_q, mode_d;
  pos_e               pos_q, pos_d;
  logic [3:0]         sw_q, sw_d, sw_prev_q;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [BLINK_W-1:0] blink_q, blink_d, blink_inc;
  logic               phase_q, phase_d;
  logic               alarm_en_q, alarm_en_d;
  logic [2:0]         mask_q, mask_d;
  logic               sec_inc_q, min_inc_q, hour_inc_q;
  logic               sec_inc_d, min_inc_d, hour_inc_d;
  logic               asec_inc_q, amin_inc_q, ahour_inc_q;
  logic               asec_inc_d, amin_inc_d, ahour_inc_d;

  logic [3:0] press;
  logic       sw2_held, active, time_run, timeout, mode_chg, rep;
  logic       inc_req, set_inc, alm_inc;

  always_comb begin
    sw_d     = {i_sw3, i_sw2, i_sw1, i_sw0};
    press    = sw_prev_q & ~sw_q;
    sw2_held = ~sw_q[2];
    active   = (mode_q == MODE_SETUP) || (mode_q == MODE_ALARM);
    time_run = (mode_q == MODE_CLOCK) || (mode_q == MODE_ALARM);
    timeout  = active && (idle_q >= IDLE_MAX_C);

    // Illegal encoding recovers first; a mode key beats the idle timeout.
    mode_d   = mode_q;
    mode_chg = 1'b0;
    if (!(active || (mode_q == MODE_CLOCK))) begin
      mode_d   = MODE_CLOCK;
      mode_chg = 1'b1;
    end else if (press[0]) begin
      mode_chg = 1'b1;
      case (mode_q)
        MODE_CLOCK: mode_d = MODE_SETUP;
        MODE_SETUP: mode_d = MODE_ALARM;
        default:    mode_d = MODE_CLOCK;
      endcase
    end else if (timeout) begin
      mode_d   = MODE_CLOCK;
      mode_chg = 1'b1;
    end

    pos_d = pos_q;
    if (mode_chg) begin
      pos_d = POS_SEC;
    end else if (press[1] && active) begin
      case (pos_q)
        POS_SEC: pos_d = POS_MIN;
        POS_MIN: pos_d = POS_HOUR;
        default: pos_d = POS_SEC;
      endcase
    end

    alarm_en_d = alarm_en_q ^ press[3];

    // Hold counter parks at REPEAT_DLY after each repeat so it never exceeds HOLD_MAX.
    hold_inc = hold_q + 1'b1;
    hold_d   = hold_q;
    rep      = 1'b0;
    if (!sw2_held || !active || mode_chg) begin
      hold_d = '0;
    end else if (i_tick_100hz) begin
      if (hold_inc == HOLD_MAX_C) begin
        hold_d = HOLD_DLY_C;
        rep    = 1'b1;
      end else begin
        hold_d = hold_inc;
        rep    = (hold_inc == HOLD_DLY_C);
      end
    end

    inc_req = (press[2] | rep) & active & ~press[0] & ~press[1] & ~mode_chg;
    set_inc = inc_req && (mode_q == MODE_SETUP);
    alm_inc = inc_req && (mode_q == MODE_ALARM);

    sec_inc_d   = time_run ? i_tick_1hz    : (set_inc && (pos_q == POS_SEC));
    min_inc_d   = time_run ? i_max_hit_sec : (set_inc && (pos_q == POS_MIN));
    hour_inc_d  = time_run ? i_max_hit_min : (set_inc && (pos_q == POS_HOUR));
    asec_inc_d  = alm_inc && (pos_q == POS_SEC);
    amin_inc_d  = alm_inc && (pos_q == POS_MIN);
    ahour_inc_d = alm_inc && (pos_q == POS_HOUR);

    idle_d = idle_q;
    if (!active || mode_chg || (|press) || sw2_held) begin
      idle_d = '0;
    end else if (i_tick_100hz && (idle_q < IDLE_MAX_C)) begin
      idle_d = idle_q + 1'b1;
    end

    blink_inc = blink_q + 1'b1;
    blink_d   = blink_q;
    phase_d   = phase_q;
    if (mode_chg) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (i_tick_100hz) begin
      if (blink_inc == BLINK_HALF_C) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_inc;
      end
    end

    // Mask tracks the next-state registers so it lines up with o_mode/o_position.
    mask_d = 3'b000;
    if (phase_d && i_sw2 && ((mode_d == MODE_SETUP) || (mode_d == MODE_ALARM))) begin
      case (pos_d)
        POS_SEC:  mask_d = 3'b001;
        POS_MIN:  mask_d = 3'b010;
        POS_HOUR: mask_d = 3'b100;
        default:  mask_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= MODE_CLOCK;
      pos_q       <= POS_SEC;
      sw_q        <= 4'hF;
      sw_prev_q   <= 4'hF;
      hold_q      <= '0;
      idle_q      <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      alarm_en_q  <= 1'b0;
      mask_q      <= 3'b000;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      asec_inc_q  <= 1'b0;
      amin_inc_q  <= 1'b0;
      ahour_inc_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      sw_q        <= sw_d;
      sw_prev_q   <= sw_q;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      alarm_en_q  <= alarm_en_d;
      mask_q      <= mask_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      asec_inc_q  <= asec_inc_d;
      amin_inc_q  <= amin_inc_d;
      ahour_inc_q <= ahour_inc_d;
    end
  end

  assign o_mode           = mode_q;
  assign o_position       = pos_q;
  assign o_alarm_en       = alarm_en_q;
  assign o_blink_mask     = mask_q;
  assign o_sec_inc        = sec_inc_q;
  assign o_min_inc        = min_inc_q;
  assign o_hour_inc       = hour_inc_q;
  assign o_alarm_sec_inc  = asec_inc_q;
  assign o_alarm_min_inc  = amin_inc_q;
  assign o_alarm_hour_inc = ahour_inc_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: modes, increments, auto-repeat, blink, idle timeout, reset.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick100, tick1, max_sec, max_min;
  logic [3:0] sw;
  logic [1:0] o_mode, o_position;
  logic       o_sec_inc, o_min_inc, o_hour_inc;
  logic       o_alarm_sec_inc, o_alarm_min_inc, o_alarm_hour_inc;
  logic       o_alarm_en;
  logic [2:0] o_blink_mask;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_sec = 0, cnt_min = 0, cnt_hour = 0, cnt_asec = 0, cnt_amin = 0, cnt_ahour = 0;
  int mask_bad = 0;
  int b_sec, b_min, b_hour, b_asec, b_amin, b_ahour;
  logic hold_mon = 1'b0;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_tick_100hz     (tick100),
    .i_tick_1hz       (tick1),
    .i_sw0            (sw[0]),
    .i_sw1            (sw[1]),
    .i_sw2            (sw[2]),
    .i_sw3            (sw[3]),
    .i_max_hit_sec    (max_sec),
    .i_max_hit_min    (max_min),
    .o_mode           (o_mode),
    .o_position       (o_position),
    .o_sec_inc        (o_sec_inc),
    .o_min_inc        (o_min_inc),
    .o_hour_inc       (o_hour_inc),
    .o_alarm_sec_inc  (o_alarm_sec_inc),
    .o_alarm_min_inc  (o_alarm_min_inc),
    .o_alarm_hour_inc (o_alarm_hour_inc),
    .o_alarm_en       (o_alarm_en),
    .o_blink_mask     (o_blink_mask)
  );

  // Pulse counters sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (o_sec_inc)        cnt_sec++;
    if (o_min_inc)        cnt_min++;
    if (o_hour_inc)       cnt_hour++;
    if (o_alarm_sec_inc)  cnt_asec++;
    if (o_alarm_min_inc)  cnt_amin++;
    if (o_alarm_hour_inc) cnt_ahour++;
    if (hold_mon && (o_blink_mask != 3'b000)) mask_bad++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int k);
    @(negedge clk) sw[k] = 1'b0;
    step(2);
    sw[k] = 1'b1;
    step(2);
  endtask

  task automatic pulse_100();
    @(negedge clk) tick100 = 1'b1;
    @(negedge clk) tick100 = 1'b0;
  endtask

  task automatic snap();
    b_sec = cnt_sec; b_min = cnt_min; b_hour = cnt_hour;
    b_asec = cnt_asec; b_amin = cnt_amin; b_ahour = cnt_ahour;
  endtask

  function automatic logic [31:0] all_delta();
    return 32'((cnt_sec - b_sec) + (cnt_min - b_min) + (cnt_hour - b_hour) +
               (cnt_asec - b_asec) + (cnt_amin - b_amin) + (cnt_ahour - b_ahour));
  endfunction

  initial begin
    rst_n = 1'b0; sw = 4'hF; tick100 = 1'b0; tick1 = 1'b0; max_sec = 1'b0; max_min = 1'b0;
    step(3);
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_pos", 32'(o_position), 32'd0);
    check("rst_alarm_en", 32'(o_alarm_en), 32'd0);
    check("rst_mask", 32'(o_blink_mask), 32'd0);
    check("rst_incs", 32'({o_sec_inc, o_min_inc, o_hour_inc,
                           o_alarm_sec_inc, o_alarm_min_inc, o_alarm_hour_inc}), 32'd0);

    @(negedge clk) rst_n = 1'b1;
    step(1);
    snap();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) tick1 = 1'b1;
      @(negedge clk) tick1 = 1'b0;
      check("clock_sec_inc_hi", 32'(o_sec_inc), 32'd1);
      step(1);
      check("clock_sec_inc_lo", 32'(o_sec_inc), 32'd0);
    end
    check("clock_sec_inc_count", 32'(cnt_sec - b_sec), 32'd3);
    @(negedge clk) max_sec = 1'b1;
    @(negedge clk) max_sec = 1'b0;
    check("clock_min_carry", 32'(o_min_inc), 32'd1);
    @(negedge clk) max_min = 1'b1;
    @(negedge clk) max_min = 1'b0;
    check("clock_hour_carry", 32'(o_hour_inc), 32'd1);

    // CLOCK -> SETUP -> ALARM, pick MIN, tap increment.
    tap(0);
    check("mode_setup", 32'(o_mode), 32'd1);
    @(negedge clk) tick1 = 1'b1;
    @(negedge clk) tick1 = 1'b0;
    check("setup_halts_sec", 32'(o_sec_inc), 32'd0);
    tap(0);
    check("mode_alarm", 32'(o_mode), 32'd2);
    tap(1);
    check("alarm_pos_min", 32'(o_position), 32'd1);
    snap();
    tap(2);
    check("alarm_min_inc_count", 32'(cnt_amin - b_amin), 32'd1);
    check("alarm_other_incs", 32'(all_delta()), 32'd1);
    @(negedge clk) tick1 = 1'b1;
    @(negedge clk) tick1 = 1'b0;
    check("alarm_sec_follows", 32'(o_sec_inc), 32'd1);
    tap(3);
    check("alarm_en_toggle", 32'(o_alarm_en), 32'd1);

    // Auto-repeat on HOUR in SETUP.
    tap(0);
    check("back_to_clock", 32'(o_mode), 32'd0);
    tap(0);
    tap(1);
    tap(1);
    check("setup_pos_hour", 32'(o_position), 32'd2);
    snap();
    @(negedge clk) sw[2] = 1'b0;
    step(2);
    hold_mon = 1'b1;
    check("hold_press_pulse", 32'(cnt_hour - b_hour), 32'd1);
    for (int t = 1; t <= 100; t++) begin
      pulse_100();
      if (t == 49) check("hold_before_dly", 32'(cnt_hour - b_hour), 32'd1);
      if (t == 50) check("hold_first_repeat", 32'(cnt_hour - b_hour), 32'd2);
    end
    hold_mon = 1'b0;
    check("hold_hour_total", 32'(cnt_hour - b_hour), 32'd7);
    check("hold_only_hour", 32'(all_delta()), 32'd7);
    check("hold_mask_blank", 32'(mask_bad), 32'd0);
    @(negedge clk) sw[2] = 1'b1;
    step(2);

    // Idle in SETUP/HOUR: blink and timeout.
    check("idle_mask_start", 32'(o_blink_mask), 32'd0);
    for (int t = 1; t <= 1000; t++) begin
      pulse_100();
      if (t == 24)  check("blink_t24", 32'(o_blink_mask), 32'b000);
      if (t == 25)  check("blink_t25", 32'(o_blink_mask), 32'b100);
      if (t == 49)  check("blink_t49", 32'(o_blink_mask), 32'b100);
      if (t == 50)  check("blink_t50", 32'(o_blink_mask), 32'b000);
      if (t == 999) check("blink_t999", 32'(o_blink_mask), 32'b100);
      if (t == 999) check("idle_t999_mode", 32'(o_mode), 32'd1);
    end
    check("idle_t1000_mode", 32'(o_mode), 32'd1);
    step(1);
    check("idle_timeout_mode", 32'(o_mode), 32'd0);
    check("idle_timeout_pos", 32'(o_position), 32'd0);
    check("idle_timeout_mask", 32'(o_blink_mask), 32'd0);

    // sw0+sw2 together, then sw1+sw2 together.
    tap(0);
    snap();
    @(negedge clk) begin sw[0] = 1'b0; sw[2] = 1'b0; end
    step(2);
    check("sw0_sw2_mode", 32'(o_mode), 32'd2);
    sw = 4'hF;
    step(2);
    check("sw0_sw2_no_inc", 32'(all_delta()), 32'd0);
    snap();
    @(negedge clk) begin sw[1] = 1'b0; sw[2] = 1'b0; end
    step(2);
    check("sw1_sw2_pos", 32'(o_position), 32'd1);
    sw = 4'hF;
    step(2);
    check("sw1_sw2_no_inc", 32'(all_delta()), 32'd0);

    // Reset in the middle of an auto-repeat hold.
    tap(0);
    tap(0);
    check("reset_test_setup", 32'(o_mode), 32'd1);
    snap();
    @(negedge clk) sw[2] = 1'b0;
    step(2);
    for (int t = 1; t <= 55; t++) pulse_100();
    check("pre_reset_sec_incs", 32'(cnt_sec - b_sec), 32'd2);
    @(negedge clk) rst_n = 1'b0;
    step(2);
    check("midhold_rst_mode", 32'(o_mode), 32'd0);
    check("midhold_rst_pos", 32'(o_position), 32'd0);
    check("midhold_rst_alarm_en", 32'(o_alarm_en), 32'd0);
    check("midhold_rst_mask", 32'(o_blink_mask), 32'd0);
    check("midhold_rst_incs", 32'({o_sec_inc, o_min_inc, o_hour_inc,
                                   o_alarm_sec_inc, o_alarm_min_inc, o_alarm_hour_inc}), 32'd0);
    snap();
    @(negedge clk) rst_n = 1'b1;
    for (int t = 1; t <= 60; t++) pulse_100();
    check("post_reset_no_inc", 32'(all_delta()), 32'd0);
    check("post_reset_mode", 32'(o_mode), 32'd0);
    @(negedge clk) sw[2] = 1'b1;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
